regfile_mp: RTL
===============

Name: regfile_mp

Overview:
Parametrised multi-read-port register file for the MIPS_32 datapath, successor to the single-write/two-read file.
- NUM_RD independently enabled read ports, each with registered output.
- One write port with write-to-read bypass.
- Optional hard-wired zero register.
- Post-reset scrub FSM clears every entry one word per cycle, so the storage can map to distributed/block RAM.

Parameters:
DATA_W, 32, data word width in bits
ADDR_W, 5, register address width; DEPTH = 2**ADDR_W entries
NUM_RD, 2, number of read ports (1..4)
ZERO_REG, 1, 1 = entry 0 always reads 0 and ignores writes; 0 = entry 0 is an ordinary register

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
we  input  1  write enable
wa  input  ADDR_W  write address
wd  input  DATA_W  write data
re  input  NUM_RD  per-port read enable; bit i controls port i
ra  input  NUM_RD*ADDR_W  read addresses; port i at [i*ADDR_W +: ADDR_W]
rd  output  NUM_RD*DATA_W  registered read data; port i at [i*DATA_W +: DATA_W]
ready  output  1  1 = scrub finished, reads and writes accepted

Behaviour:
- Interface: one clock (clk). Reset rst is synchronous and active-high, sampled on the rising edge of clk.
- FSM states: INIT and RUN.
- Reset:
  - rst=1 at an edge -> state=INIT, clr_cnt=0, rd=0 on all ports, ready=0.
  - rst dominates every other input.
  - rst asserted mid-INIT restarts clr_cnt at 0.
  - rst asserted in RUN re-enters INIT; all contents are cleared again.
- INIT:
  - Each cycle: mem[clr_cnt] <= 0, then clr_cnt += 1.
  - When clr_cnt == DEPTH-1 is written, next state=RUN and ready=1 the following cycle.
  - ready first reads 1 exactly DEPTH cycles after the last rst=1 edge (32 with defaults).
  - we is ignored; the write is dropped, with no queueing.
  - re is ignored; rd holds 0.
- RUN, write:
  - we_eff = we & ready & ~(ZERO_REG & (wa==0)).
  - If we_eff=1, mem[wa] <= wd at the edge.
- RUN, read, for each port i independently:
  - Latency is 1 cycle.
  - If re[i]=1 at an edge, rd_i <= 0 when ZERO_REG & (ra_i==0).
  - Otherwise rd_i <= wd when we_eff & (wa==ra_i); this is the bypass, so new data is returned.
  - Otherwise rd_i <= mem[ra_i].
  - If re[i]=0, rd_i holds its previous value.
  - Reads are never suppressed by a simultaneous write. The old single-port file blocked reads on we; that behaviour is removed.
- Simultaneous events:
  - Multiple ports may read the same address; each gets identical data.
  - A write plus reads of other addresses in the same cycle: the reads return old contents of their own addresses.
- Counter width: clr_cnt is ADDR_W+1 bits wide, so there is no wrap before the terminal compare.
- No X propagation: every rd bit is defined from reset onward.

Decomposition:
- Shared package mips_pkg:
  - DATA_W and ADDR_W defaults.
  - Enum rf_state_t {RF_INIT, RF_RUN}.
  - Constant RF_ZERO_ADDR = 0.
- Natural sub-module: regfile_rd_port.
  - One instance per read port via generate.
  - Contains the address decode, zero-register check, bypass mux and output register.
- Storage array, write logic and scrub FSM stay in regfile_mp.

Test Plan:
1. Scrub: pulse rst 1 cycle, hold we=1, wa=5, wd=0xDEAD_BEEF during INIT -> ready rises exactly 32 cycles after the rst edge; a later read of reg 5 returns 0x0000_0000 (write dropped).
2. Basic write/read: we=1, wa=7, wd=0x1234_5678; next cycle re=2'b01, ra0=7 -> rd0=0x1234_5678 one cycle later; rd1 holds its prior value.
3. Bypass: in one cycle we=1, wa=9, wd=0xA5A5_A5A5 and re=2'b11, ra0=9, ra1=9 -> both rd0 and rd1 = 0xA5A5_A5A5 after that edge.
4. Zero register, ZERO_REG=1: write wa=0, wd=0xFFFF_FFFF, then read ra0=0 -> rd0=0. Same stimulus with ZERO_REG=0 -> rd0=0xFFFF_FFFF.
5. Reset mid-INIT and in RUN: after reg 3 holds 0x55, assert rst; on cycle 10 of INIT assert rst again -> ready rises 32 cycles after the second rst edge; reg 3 reads 0.
6. Port scaling, NUM_RD=4, DATA_W=16: four distinct addresses 1..4 written with 0x0011, 0x0022, 0x0033, 0x0044, then all read in one cycle -> each rd_i returns its value; re=4'b0000 on the next cycle -> all rd_i unchanged.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS_32 datapath: default widths, register-file
// controller states and architectural constants.
package mips_pkg;

    localparam int MIPS_DATA_W = 32;
    localparam int MIPS_ADDR_W = 5;

    typedef enum logic {
        RF_INIT,
        RF_RUN
    } rf_state_t;

    // Architectural zero register ($zero)
    localparam int RF_ZERO_ADDR = 0;

endpackage

// File: rtl/regfile_rd_port.sv
// One registered read port of the register file: address decode, zero-register
// forcing, write-to-read bypass and the output register.
module regfile_rd_port
    import mips_pkg::*;
#(
    parameter int DATA_W   = MIPS_DATA_W,
    parameter int ADDR_W   = MIPS_ADDR_W,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [ADDR_W-1:0] ra,
    input  logic              we_eff,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [DATA_W-1:0] mem [1<<ADDR_W],
    output logic [DATA_W-1:0] rd
);

    logic [DATA_W-1:0] rd_next;

    // NOTE: rd_next gets a value before any condition so no latch is inferred.
    // Priority: zero register, then bypass of the write in flight, then storage.
    always_comb begin
        rd_next = mem[ra];
        if (we_eff && (wa == ra)) begin
            rd_next = wd;
        end
        if (ZERO_REG && (ra == ADDR_W'(RF_ZERO_ADDR))) begin
            rd_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd <= '0;
        end else if (en) begin
            rd <= rd_next;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file: one bypassed write port, NUM_RD registered read
// ports and a post-reset scrub that zeroes every entry before accepting traffic.
module regfile_mp
    import mips_pkg::*;
#(
    parameter int DATA_W   = MIPS_DATA_W,
    parameter int ADDR_W   = MIPS_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        wa,
    input  logic [DATA_W-1:0]        wd,
    input  logic [NUM_RD-1:0]        re,
    input  logic [NUM_RD*ADDR_W-1:0] ra,
    output logic [NUM_RD*DATA_W-1:0] rd,
    output logic                     ready
);

    localparam int DEPTH = 1 << ADDR_W;

    rf_state_t         state;
    rf_state_t         state_nxt;
    logic [ADDR_W:0]   clr_cnt;
    logic [ADDR_W:0]   clr_cnt_nxt;
    logic              scrub_we;
    logic              we_eff;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_wa;
    logic [DATA_W-1:0] mem_wd;
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= RF_INIT;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
        end
    end

    // Scrub walks every entry once; the counter is one bit wider than the address
    // so the terminal compare is reached before any wrap.
    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        scrub_we    = 1'b0;
        case (state)
            RF_INIT: begin
                scrub_we    = 1'b1;
                clr_cnt_nxt = clr_cnt + 1'b1;
                if (clr_cnt == (ADDR_W+1)'(DEPTH - 1)) begin
                    state_nxt = RF_RUN;
                end
            end
            RF_RUN: begin
                state_nxt = RF_RUN;
            end
            default: begin
                state_nxt = RF_INIT;
            end
        endcase
    end

    assign ready  = (state == RF_RUN);
    assign we_eff = we && ready && !rst && !(ZERO_REG && (wa == ADDR_W'(RF_ZERO_ADDR)));

    assign mem_we = !rst && (scrub_we || we_eff);
    assign mem_wa = scrub_we ? clr_cnt[ADDR_W-1:0] : wa;
    assign mem_wd = scrub_we ? '0 : wd;

    // NOTE: storage has no reset so it can map onto RAM; the scrub clears it instead.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        regfile_rd_port #(
            .DATA_W  (DATA_W),
            .ADDR_W  (ADDR_W),
            .ZERO_REG(ZERO_REG)
        ) u_port (
            .clk   (clk),
            .rst   (rst),
            .en    (ready && re[i]),
            .ra    (ra[i*ADDR_W +: ADDR_W]),
            .we_eff(we_eff),
            .wa    (wa),
            .wd    (wd),
            .mem   (mem),
            .rd    (rd[i*DATA_W +: DATA_W])
        );
    end

endmodule
